// File: rtl/muldiv_wb_arbiter_if.sv
// Bus bundle for the mult/div writeback arbiter: multiplier issue/result,
// divider result handshake and the shared writeback port.
interface muldiv_wb_arbiter_if #(
   parameter int XLEN          = 64,
   parameter int TRANS_ID_BITS = 3
);
   logic                     mul_issue_i;
   logic                     mul_issue_ready_o;
   logic                     mul_valid_i;
   logic [XLEN-1:0]          mul_result_i;
   logic [TRANS_ID_BITS-1:0] mul_trans_id_i;
   logic                     div_valid_i;
   logic                     div_ready_o;
   logic [XLEN-1:0]          div_result_i;
   logic [TRANS_ID_BITS-1:0] div_trans_id_i;
   logic                     wb_valid_o;
   logic                     wb_ready_i;
   logic [XLEN-1:0]          wb_result_o;
   logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
   logic                     wb_src_o;
   logic                     ovf_err_o;

   modport slave (
      input  mul_issue_i, mul_valid_i, mul_result_i, mul_trans_id_i,
      input  div_valid_i, div_result_i, div_trans_id_i, wb_ready_i,
      output mul_issue_ready_o, div_ready_o, wb_valid_o, wb_result_o,
      output wb_trans_id_o, wb_src_o, ovf_err_o
   );

   modport master (
      output mul_issue_i, mul_valid_i, mul_result_i, mul_trans_id_i,
      output div_valid_i, div_result_i, div_trans_id_i, wb_ready_i,
      input  mul_issue_ready_o, div_ready_o, wb_valid_o, wb_result_o,
      input  wb_trans_id_o, wb_src_o, ovf_err_o
   );
endinterface

// File: rtl/muldiv_wb_arbiter.sv
// Writeback arbiter + multiplier issue-credit controller for the mult/div unit.
// MULDIV_ARB_FAIRNESS_EN enables divider anti-starvation; MULDIV_ARB_OVF_ASSERT enables the overflow assertion.
module muldiv_wb_arbiter #(
   parameter int XLEN           = 64,
   parameter int TRANS_ID_BITS  = 3,
   parameter int MUL_FIFO_DEPTH = 4,
   parameter int MAX_DIV_WAIT   = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   muldiv_wb_arbiter_if.slave bus
);
   localparam int AW = $clog2(MUL_FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = TRANS_ID_BITS + XLEN;

   if (MUL_FIFO_DEPTH < 2 || (MUL_FIFO_DEPTH & (MUL_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("MUL_FIFO_DEPTH must be a power of two >= 2");
   end
   if (MAX_DIV_WAIT < 1) begin : g_bad_wait
      $error("MAX_DIV_WAIT must be >= 1");
   end

   logic [EW-1:0] mem_q [MUL_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] credits_q, credits_d;
   logic          ovf_q;
   logic [EW-1:0] head;
   logic          fifo_empty, fifo_full;
   logic          div_sel, mul_grant, force_div;
   logic          push, pop, ovf_evt;

   assign head       = mem_q[rd_ptr_q];
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(MUL_FIFO_DEPTH));

   // Divider only counts as granted when it actually has a result to offer.
   assign div_sel   = bus.div_valid_i & (fifo_empty | force_div);
   assign mul_grant = ~fifo_empty & ~div_sel;
   assign pop       = mul_grant & bus.wb_ready_i;
   assign push      = bus.mul_valid_i & (~fifo_full | pop);
   assign ovf_evt   = bus.mul_valid_i & fifo_full & ~pop;

`ifdef MULDIV_ARB_FAIRNESS_EN
   localparam int WW = $clog2(MAX_DIV_WAIT + 1);
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!bus.div_valid_i || (div_sel && bus.wb_ready_i))
         wait_cnt_d = '0;
      else if (pop && wait_cnt_q < WW'(MAX_DIV_WAIT))
         wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) wait_cnt_q <= '0;
      else       wait_cnt_q <= wait_cnt_d;
   end

   assign force_div = (wait_cnt_q >= WW'(MAX_DIV_WAIT));
`else
   assign force_div = 1'b0;
`endif

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      credits_d = credits_q;
      case ({bus.mul_issue_i, pop})
         2'b10:   credits_d = credits_q - 1'b1;
         2'b01:   credits_d = credits_q + 1'b1;
         default: credits_d = credits_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         credits_q <= CW'(MUL_FIFO_DEPTH);
         ovf_q     <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q   <= count_d;
         credits_q <= credits_d;
         if (ovf_evt) ovf_q <= 1'b1;
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {bus.mul_trans_id_i, bus.mul_result_i};
   end

   always_comb begin
      bus.wb_valid_o        = ~fifo_empty | bus.div_valid_i;
      bus.wb_src_o          = div_sel;
      bus.wb_result_o       = '0;
      bus.wb_trans_id_o     = '0;
      if (div_sel) begin
         bus.wb_result_o   = bus.div_result_i;
         bus.wb_trans_id_o = bus.div_trans_id_i;
      end else if (mul_grant) begin
         bus.wb_result_o   = head[XLEN-1:0];
         bus.wb_trans_id_o = head[EW-1:XLEN];
      end
      bus.div_ready_o       = bus.wb_ready_i & div_sel;
      bus.mul_issue_ready_o = (credits_q != '0);
      bus.ovf_err_o         = ovf_q;
   end

`ifdef MULDIV_ARB_OVF_ASSERT
   // A full buffer with no pop means the issue stage ignored its credits.
   ovf_never_a: assert property (@(posedge clk_i) disable iff (rst_i) !ovf_evt);
`endif
endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Directed bench for muldiv_wb_arbiter: reset, credits, ordering, arbitration, overflow.
// Arbitration expectations follow MULDIV_ARB_FAIRNESS_EN (fair with MAX_DIV_WAIT=2, else strict).
module tb_muldiv_wb_arbiter;
   localparam int XLEN  = 64;
   localparam int IDW   = 3;
   localparam int DEPTH = 4;
   localparam int MAXW  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   muldiv_wb_arbiter_if #(.XLEN(XLEN), .TRANS_ID_BITS(IDW)) bus ();

   muldiv_wb_arbiter #(
      .XLEN(XLEN), .TRANS_ID_BITS(IDW), .MUL_FIFO_DEPTH(DEPTH), .MAX_DIV_WAIT(MAXW)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   function automatic logic [XLEN-1:0] mres(input int id);
      return 64'hA5A5_0000_0000_0000 + 64'(id);
   endfunction

   function automatic logic [XLEN-1:0] dres(input int id);
      return 64'hD1D1_0000_0000_0000 + 64'(id);
   endfunction

   task automatic idle();
      bus.mul_issue_i    = 1'b0;
      bus.mul_valid_i    = 1'b0;
      bus.mul_result_i   = '0;
      bus.mul_trans_id_i = '0;
      bus.div_valid_i    = 1'b0;
      bus.div_result_i   = '0;
      bus.div_trans_id_i = '0;
      bus.wb_ready_i     = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_mul(input int id, input logic issue);
      bus.mul_issue_i    = issue;
      bus.mul_valid_i    = 1'b1;
      bus.mul_trans_id_i = 3'(id);
      bus.mul_result_i   = mres(id);
   endtask

   task automatic clear_mul();
      bus.mul_issue_i = 1'b0;
      bus.mul_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (bus.wb_valid_o !== 1'b0) $display("FAIL rst_wb_valid: got %b want 0", bus.wb_valid_o); else passed++;
      checks++; if (bus.wb_src_o !== 1'b0) $display("FAIL rst_wb_src: got %b want 0", bus.wb_src_o); else passed++;
      checks++; if (bus.wb_result_o !== '0) $display("FAIL rst_wb_result: got %h want 0", bus.wb_result_o); else passed++;
      checks++; if (bus.wb_trans_id_o !== '0) $display("FAIL rst_wb_id: got %0d want 0", bus.wb_trans_id_o); else passed++;
      checks++; if (bus.div_ready_o !== 1'b0) $display("FAIL rst_div_ready: got %b want 0", bus.div_ready_o); else passed++;
      checks++; if (bus.ovf_err_o !== 1'b0) $display("FAIL rst_ovf: got %b want 0", bus.ovf_err_o); else passed++;
      checks++; if (bus.mul_issue_ready_o !== 1'b1) $display("FAIL rst_issue_ready: got %b want 1", bus.mul_issue_ready_o); else passed++;
      tick();
      rst = 1'b0;
      tick();
      push_mul(1, 1'b1);
      tick();
      push_mul(2, 1'b1);
      tick();
      idle();
      @(negedge clk);
      checks++; if (bus.wb_valid_o !== 1'b1 || bus.wb_trans_id_o !== 3'd1) $display("FAIL midrst_pre: got v=%b id=%0d want v=1 id=1", bus.wb_valid_o, bus.wb_trans_id_o); else passed++;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.wb_valid_o !== 1'b0) $display("FAIL midrst_wb_valid: got %b want 0", bus.wb_valid_o); else passed++;
      checks++; if (bus.mul_issue_ready_o !== 1'b1) $display("FAIL midrst_issue_ready: got %b want 1", bus.mul_issue_ready_o); else passed++;
      checks++; if (bus.ovf_err_o !== 1'b0) $display("FAIL midrst_ovf: got %b want 0", bus.ovf_err_o); else passed++;
      tick();
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_credit();
      bus.wb_ready_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.mul_issue_i = 1'b1;
         @(negedge clk);
         checks++; if (bus.mul_issue_ready_o !== 1'b1) $display("FAIL credit_avail%0d: got %b want 1", i, bus.mul_issue_ready_o); else passed++;
         tick();
      end
      bus.mul_issue_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         push_mul(4 + i, 1'b0);
         @(negedge clk);
         checks++; if (bus.mul_issue_ready_o !== 1'b0) $display("FAIL credit_empty%0d: got %b want 0", i, bus.mul_issue_ready_o); else passed++;
         tick();
      end
      idle();
      @(negedge clk);
      checks++; if (bus.wb_valid_o !== 1'b1 || bus.wb_trans_id_o !== 3'd4) $display("FAIL credit_head: got v=%b id=%0d want v=1 id=4", bus.wb_valid_o, bus.wb_trans_id_o); else passed++;
      tick();
      bus.wb_ready_i = 1'b1;
      @(negedge clk);
      checks++; if (bus.mul_issue_ready_o !== 1'b0) $display("FAIL credit_pop_same_cycle: got %b want 0", bus.mul_issue_ready_o); else passed++;
      $display("wb src=%b id=%0d", bus.wb_src_o, bus.wb_trans_id_o);
      tick();
      bus.wb_ready_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.mul_issue_ready_o !== 1'b1) $display("FAIL credit_return: got %b want 1", bus.mul_issue_ready_o); else passed++;
      tick();
      bus.wb_ready_i = 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
         @(negedge clk);
         checks++; if (bus.wb_trans_id_o !== 3'(4 + i) || bus.wb_src_o !== 1'b0 || bus.wb_result_o !== mres(4 + i))
            $display("FAIL credit_drain%0d: got id=%0d src=%b res=%h want id=%0d src=0 res=%h", i, bus.wb_trans_id_o, bus.wb_src_o, bus.wb_result_o, 4 + i, mres(4 + i));
         else passed++;
         $display("wb src=%b id=%0d", bus.wb_src_o, bus.wb_trans_id_o);
         tick();
      end
      idle();
      @(negedge clk);
      checks++; if (bus.wb_valid_o !== 1'b0 || bus.mul_issue_ready_o !== 1'b1) $display("FAIL credit_final: got v=%b rdy=%b want v=0 rdy=1", bus.wb_valid_o, bus.mul_issue_ready_o); else passed++;
      tick();
   endtask

   task automatic test_mul_order();
      bus.wb_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) push_mul(i + 1, 1'b1);
         else       clear_mul();
         @(negedge clk);
         if (i == 0 || i == 4) begin
            checks++; if (bus.wb_valid_o !== 1'b0) $display("FAIL order_idle%0d: got v=%b want 0", i, bus.wb_valid_o); else passed++;
         end else begin
            checks++; if (bus.wb_valid_o !== 1'b1 || bus.wb_src_o !== 1'b0 || bus.wb_trans_id_o !== 3'(i) || bus.wb_result_o !== mres(i))
               $display("FAIL order%0d: got v=%b src=%b id=%0d res=%h want v=1 src=0 id=%0d res=%h", i, bus.wb_valid_o, bus.wb_src_o, bus.wb_trans_id_o, bus.wb_result_o, i, mres(i));
            else passed++;
            $display("wb src=%b id=%0d", bus.wb_src_o, bus.wb_trans_id_o);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_arbitration();
`ifdef MULDIV_ARB_FAIRNESS_EN
      int push_t[8] = '{4, 6, 0, 0, 0, 0, 0, 0};
      int div_t[8]  = '{5, 5, 5, 7, 7, 7, 0, 0};
      int v_t[8]    = '{1, 1, 1, 1, 1, 1, 1, 0};
      int src_t[8]  = '{0, 0, 1, 0, 0, 1, 0, 0};
      int id_t[8]   = '{1, 2, 5, 3, 4, 7, 6, 0};
`else
      int push_t[8] = '{4, 6, 0, 0, 0, 0, 0, 0};
      int div_t[8]  = '{5, 5, 5, 5, 5, 5, 0, 0};
      int v_t[8]    = '{1, 1, 1, 1, 1, 1, 0, 0};
      int src_t[8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
      int id_t[8]   = '{1, 2, 3, 4, 6, 5, 0, 0};
`endif
      bus.wb_ready_i = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         push_mul(i, 1'b1);
         tick();
      end
      clear_mul();
      bus.wb_ready_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (push_t[c] != 0) push_mul(push_t[c], 1'b1);
         else                clear_mul();
         bus.div_valid_i    = (div_t[c] != 0);
         bus.div_trans_id_i = 3'(div_t[c]);
         bus.div_result_i   = (div_t[c] != 0) ? dres(div_t[c]) : '0;
         @(negedge clk);
         checks++; if (bus.wb_valid_o !== 1'(v_t[c])) $display("FAIL arb_valid%0d: got %b want %0d", c, bus.wb_valid_o, v_t[c]); else passed++;
         if (v_t[c] != 0) begin
            checks++; if (bus.wb_src_o !== 1'(src_t[c]) || bus.wb_trans_id_o !== 3'(id_t[c]))
               $display("FAIL arb_grant%0d: got src=%b id=%0d want src=%0d id=%0d", c, bus.wb_src_o, bus.wb_trans_id_o, src_t[c], id_t[c]);
            else passed++;
            checks++; if (bus.wb_result_o !== ((src_t[c] != 0) ? dres(id_t[c]) : mres(id_t[c])))
               $display("FAIL arb_result%0d: got %h", c, bus.wb_result_o);
            else passed++;
            $display("wb src=%b id=%0d", bus.wb_src_o, bus.wb_trans_id_o);
         end
         checks++; if (bus.div_ready_o !== 1'(src_t[c])) $display("FAIL arb_div_ready%0d: got %b want %0d", c, bus.div_ready_o, src_t[c]); else passed++;
         tick();
      end
      idle();
      @(negedge clk);
      checks++; if (bus.mul_issue_ready_o !== 1'b1) $display("FAIL arb_credits: got %b want 1", bus.mul_issue_ready_o); else passed++;
      tick();
   endtask

   task automatic test_overflow();
      bus.wb_ready_i = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         push_mul(i, 1'b1);
         tick();
      end
      clear_mul();
      @(negedge clk);
      checks++; if (bus.mul_issue_ready_o !== 1'b0 || bus.ovf_err_o !== 1'b0) $display("FAIL ovf_full_state: got rdy=%b ovf=%b want 0 0", bus.mul_issue_ready_o, bus.ovf_err_o); else passed++;
      tick();
      push_mul(5, 1'b0);
      bus.wb_ready_i = 1'b1;
      @(negedge clk);
      checks++; if (bus.wb_trans_id_o !== 3'd1) $display("FAIL ovf_pushpop_head: got %0d want 1", bus.wb_trans_id_o); else passed++;
      tick();
      clear_mul();
      bus.wb_ready_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.ovf_err_o !== 1'b0) $display("FAIL ovf_pushpop_full: got %b want 0", bus.ovf_err_o); else passed++;
      tick();
      push_mul(7, 1'b0);
      tick();
      clear_mul();
      @(negedge clk);
      checks++; if (bus.ovf_err_o !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus.ovf_err_o); else passed++;
      tick();
      @(negedge clk);
      checks++; if (bus.ovf_err_o !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.ovf_err_o); else passed++;
      tick();
      bus.wb_ready_i = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         @(negedge clk);
         checks++; if (bus.wb_valid_o !== 1'b1 || bus.wb_trans_id_o !== 3'(i) || bus.wb_result_o !== mres(i))
            $display("FAIL ovf_contents%0d: got v=%b id=%0d res=%h want v=1 id=%0d res=%h", i, bus.wb_valid_o, bus.wb_trans_id_o, bus.wb_result_o, i, mres(i));
         else passed++;
         $display("wb src=%b id=%0d", bus.wb_src_o, bus.wb_trans_id_o);
         tick();
      end
      @(negedge clk);
      checks++; if (bus.wb_valid_o !== 1'b0 || bus.ovf_err_o !== 1'b1) $display("FAIL ovf_drained: got v=%b ovf=%b want v=0 ovf=1", bus.wb_valid_o, bus.ovf_err_o); else passed++;
      idle();
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.ovf_err_o !== 1'b0 || bus.mul_issue_ready_o !== 1'b1) $display("FAIL ovf_reset: got ovf=%b rdy=%b want 0 1", bus.ovf_err_o, bus.mul_issue_ready_o); else passed++;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_credit();
      test_mul_order();
      test_arbitration();
      test_overflow();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
